data_mem_resp: RTL and testbench
================================

DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
- REQ-001: Parameter DEPTH, default 256, number of 32-bit data-memory words.
- REQ-002: Parameter WAIT_CYCLES, default 1, extra access cycles, legal range 0..15.
- REQ-003: clk  input  1  single clock; all state updates on the rising edge.
- REQ-004: rst_n  input  1  asynchronous, active-low reset.
- REQ-005: req_valid  input  1  memory-stage request present.
- REQ-006: req_ready  output  1  responder can accept a request.
- REQ-007: req_we  input  1  1 = store (W_mem), 0 = load (R_mem).
- REQ-008: req_addr  input  32  word address (ALU result).
- REQ-009: req_wdata  input  32  store data (Rd value).
- REQ-010: rsp_valid  output  1  response present.
- REQ-011: rsp_ready  input  1  pipeline accepts the response.
- REQ-012: rsp_rdata  output  32  load data; 0 for stores and errors.
- REQ-013: rsp_err  output  1  address out of range.

Function
- REQ-014: The FSM SHALL have three states: IDLE, ACCESS and RESP.
- REQ-015: req_ready SHALL be 1 only in IDLE.
- REQ-016: IDLE: a request is accepted on an edge with req_valid=1; the block latches we/addr/wdata, loads wait_cnt=WAIT_CYCLES and goes to ACCESS.
- REQ-017: ACCESS: on each edge, if wait_cnt!=0, wait_cnt SHALL decrement; if wait_cnt==0, the access SHALL be performed and the state SHALL go to RESP.
- REQ-018: rsp_valid SHALL go high WAIT_CYCLES+1 edges after the accept edge.
  - WAIT_CYCLES=1: rsp_valid is high after the 2nd edge following accept.
- REQ-019: Address check: the full 32-bit latched address SHALL be compared; addr >= DEPTH sets rsp_err=1.
  - An erroring store SHALL write nothing.
  - An erroring load SHALL return rsp_rdata=0.
- REQ-020: A valid store SHALL write wdata at the access edge, and SHALL return rsp_err=0 and rsp_rdata=0.
- REQ-021: A valid load SHALL return mem[addr] sampled at the access edge.
- REQ-022: RESP: rsp_valid, rsp_rdata and rsp_err SHALL be held stable until an edge with rsp_ready=1, then the state SHALL return to IDLE.
- REQ-023: No new request is accepted in the cycle the response completes.
  - Minimum spacing between accepts is WAIT_CYCLES+3 edges.
- REQ-024: req_valid in ACCESS/RESP SHALL be ignored; the requester holds it.
- REQ-025: Store-then-load to the same address SHALL return the stored value (no bypass needed; accesses are serialized).
- REQ-026: rsp_rdata and rsp_err SHALL be registered outputs.

Reset
- REQ-027: rst_n low SHALL force, immediately:
  - state=IDLE, wait_cnt=0;
  - rsp_valid=0, rsp_rdata=0, rsp_err=0;
  - req_ready=1 after rst_n is released.
- REQ-028: Reset mid-ACCESS SHALL abort the transaction; a pending store SHALL NOT be written.
- REQ-029: Memory contents SHALL NOT be reset.

Structure
- REQ-030: Shared package arch_pkg SHALL hold DATA_W=32, MEM_DEPTH=256 and the typedef for the state enum mem_state_t {IDLE, ACCESS, RESP}.
- REQ-031: Storage SHALL be one sub-module, mem_array: synchronous single-port DEPTH x 32 RAM with write enable and registered read.

Verification
- REQ-032: Store addr=0x10, data=0xDEADBEEF, then load addr=0x10 -> load response rdata=0xDEADBEEF, err=0.
- REQ-033: Load addr=0x100 (DEPTH=256) -> rsp_err=1, rdata=0.
  - Store to 0x100 -> err=1; mem[0x00] is unchanged.
- REQ-034: WAIT_CYCLES=1, accept at edge N -> rsp_valid=1 after edge N+2; req_ready=0 from edge N until the response completes.
- REQ-035: Hold rsp_ready=0 for 5 cycles -> rsp_valid and rdata are stable throughout; return to IDLE on the edge with rsp_ready=1.
- REQ-036: Assert rst_n=0 during ACCESS of a store to 0x20 (old value 0x1) -> rsp_valid=0 immediately; a later load of 0x20 returns 0x1.
- REQ-037: Back-to-back requests with req_valid held high -> accepts are exactly WAIT_CYCLES+3 edges apart.

Source files
------------

// File: rtl/arch_pkg.sv
// Shared definitions for the memory-stage responder: data width, default depth
// and the responder FSM state type.
package arch_pkg;

  localparam int DATA_W    = 32;
  localparam int MEM_DEPTH = 256;
  localparam int WAIT_W    = 4;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } mem_state_t;

endpackage

// File: rtl/mem_array.sv
// Synchronous single-port data RAM with write enable and a registered read port.
// The read register is cleared on accesses that must return zero (stores, errors).
module mem_array
  import arch_pkg::*;
#(
  parameter int DEPTH  = MEM_DEPTH,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              we,
  input  logic              rd_clr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: the storage array has no reset; clearing it would need a sequencer
  // and would stop the array mapping onto a RAM macro.
  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[addr] <= wdata;
    end
  end

  // NOTE: every flop is updated with <= so all registers sample pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (en) begin
      rdata <= (we || rd_clr) ? '0 : mem[addr];
    end
  end

endmodule

// File: rtl/data_mem_resp.sv
// Memory-stage data responder: accepts one load/store, waits WAIT_CYCLES, performs
// the access on mem_array and holds a registered response until it is taken.
module data_mem_resp
  import arch_pkg::*;
#(
  parameter int DEPTH       = MEM_DEPTH,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int                ADDR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [DATA_W-1:0] DEPTH_LIM = DATA_W'(DEPTH);
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(WAIT_CYCLES);

  mem_state_t        state, state_next;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_next;
  logic              lat_we;
  logic [DATA_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              accept;
  logic              access;
  logic              in_range;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign accept    = req_ready && req_valid;
  assign access    = (state == ACCESS) && (wait_cnt == '0);
  // Full-width compare: high address bits must not alias into the array.
  assign in_range  = (lat_addr < DEPTH_LIM);

  // NOTE: every output of this block gets a default first, so no path infers a latch.
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          state_next    = ACCESS;
          wait_cnt_next = WAIT_LOAD;
        end
      end
      ACCESS: begin
        if (wait_cnt != '0) begin
          wait_cnt_next = wait_cnt - 1'b1;
        end else begin
          state_next = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      if (accept) begin
        lat_we    <= req_we;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
      end
      if (access) begin
        rsp_err <= !in_range;
      end
    end
  end

  // A reset forces IDLE, so an aborted store never reaches the write enable.
  mem_array #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem_array (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (access),
    .we     (lat_we && in_range),
    .rd_clr (!in_range),
    .addr   (lat_addr[ADDR_W-1:0]),
    .wdata  (lat_wdata),
    .rdata  (rsp_rdata)
  );

endmodule

// File: tb/tb_data_mem_resp.sv
// Self-checking bench for data_mem_resp: directed and random loads/stores checked
// against a word-array model of the data memory.
module tb_data_mem_resp;

  localparam int DEPTH       = 256;
  localparam int WAIT_CYCLES = 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int checks = 0;
  int failures = 0;

  logic [31:0] model_mem [DEPTH];

  data_mem_resp #(
    .DEPTH       (DEPTH),
    .WAIT_CYCLES (WAIT_CYCLES)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference behaviour: out-of-range words error with zero data, stores return zero.
  task automatic model_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              output logic [31:0] rdata, output logic err);
    err   = (addr >= 32'(DEPTH));
    rdata = '0;
    if (!err) begin
      if (we) model_mem[int'(addr)] = wdata;
      else    rdata = model_mem[int'(addr)];
    end
  endtask

  task automatic pick_random(output logic we, output logic [31:0] addr, output logic [31:0] wdata);
    we    = 1'($urandom_range(0, 1));
    wdata = $urandom;
    if ($urandom_range(0, 3) == 0) addr = $urandom | 32'h0000_0100;
    else                           addr = 32'($urandom_range(0, DEPTH - 1));
  endtask

  // One complete transaction; checks ready, latency, response and stability while held.
  task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input int hold, input string name);
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          lat;
    model_access(we, addr, wdata, exp_rdata, exp_err);
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s ready_before: got %b expected 1", name, req_ready);
    end
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    rsp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 40) begin
      checks++;
      if (req_ready !== 1'b0) begin
        failures++;
        $display("FAIL %s ready_busy: got %b expected 0", name, req_ready);
      end
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != WAIT_CYCLES + 1) begin
      failures++;
      $display("FAIL %s latency: got %0d edges expected %0d", name, lat, WAIT_CYCLES + 1);
    end
    for (int i = 0; i <= hold; i++) begin
      if (i > 0) begin
        @(posedge clk);
        @(negedge clk);
      end
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== exp_rdata || rsp_err !== exp_err || req_ready !== 1'b0) begin
        failures++;
        $display("FAIL %s response[%0d]: got valid=%b rdata=%h err=%b ready=%b expected 1 %h %b 0",
                 name, i, rsp_valid, rsp_rdata, rsp_err, req_ready, exp_rdata, exp_err);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s complete: got valid=%b ready=%b expected 0 1", name, rsp_valid, req_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: got valid=%b rdata=%h err=%b expected 0 0 0",
               rsp_valid, rsp_rdata, rsp_err);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: got ready=%b valid=%b expected 1 0", req_ready, rsp_valid);
    end
  endtask

  task automatic test_init_memory();
    for (int a = 0; a < DEPTH; a++) begin
      do_txn(1'b1, 32'(a), $urandom, 0, "init_store");
    end
  endtask

  task automatic test_store_load();
    do_txn(1'b1, 32'h10, 32'hDEAD_BEEF, 0, "store_10");
    do_txn(1'b0, 32'h10, 32'h0, 0, "load_10");
  endtask

  task automatic test_range_error();
    do_txn(1'b0, 32'h100, 32'h0, 0, "load_100");
    do_txn(1'b1, 32'h100, 32'hCAFE_F00D, 0, "store_100");
    do_txn(1'b0, 32'h0, 32'h0, 0, "load_00_after_err");
    do_txn(1'b1, 32'h1000_0010, 32'h1234_5678, 0, "store_alias");
    do_txn(1'b0, 32'h10, 32'h0, 0, "load_10_after_alias");
    do_txn(1'b0, 32'hFFFF_FFFF, 32'h0, 0, "load_ffffffff");
    do_txn(1'b0, 32'hFF, 32'h0, 0, "load_last_word");
  endtask

  task automatic test_hold();
    do_txn(1'b0, 32'h10, 32'h0, 5, "hold_load");
    do_txn(1'b1, 32'h11, 32'h5555_AAAA, 5, "hold_store");
  endtask

  task automatic test_reset_abort();
    logic [31:0] ignored_rdata;
    logic        ignored_err;
    do_txn(1'b1, 32'h20, 32'h1, 0, "abort_setup");
    do_txn(1'b0, 32'h20, 32'h0, 0, "abort_preload");
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h20;
    req_wdata = 32'hBAD0_BAD0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
      failures++;
      $display("FAIL abort_reset: got valid=%b rdata=%h err=%b expected 0 0 0",
               rsp_valid, rsp_rdata, rsp_err);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    ignored_err = 1'b0;
    ignored_rdata = '0;
    do_txn(1'b0, 32'h20, 32'h0, 0, "abort_load_20");
  endtask

  task automatic test_random();
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    for (int n = 0; n < 40; n++) begin
      pick_random(we, addr, wdata);
      do_txn(we, addr, wdata, $urandom_range(0, 3), "random");
    end
  endtask

  task automatic test_back_to_back();
    exp_t        q[$];
    exp_t        e;
    int          prev = -1;
    int          n_acc = 0;
    logic        just_acc = 1'b0;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    rsp_ready = 1'b1;
    pick_random(we, addr, wdata);
    req_we = we; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    for (int cyc = 0; cyc < 140; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (rsp_valid === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL b2b_unexpected_rsp: got valid=1 expected 0 at cycle %0d", cyc);
        end else begin
          e = q.pop_front();
          if (rsp_rdata !== e.rdata || rsp_err !== e.err) begin
            failures++;
            $display("FAIL b2b_rsp: got rdata=%h err=%b expected %h %b", rsp_rdata, rsp_err, e.rdata, e.err);
          end
        end
      end
      if (cyc >= 120) begin
        req_valid = 1'b0;
      end else if (just_acc) begin
        pick_random(we, addr, wdata);
        req_we = we; req_addr = addr; req_wdata = wdata;
      end
      just_acc = 1'b0;
      if (req_valid && req_ready === 1'b1) begin
        model_access(req_we, req_addr, req_wdata, e.rdata, e.err);
        q.push_back(e);
        if (prev >= 0) begin
          checks++;
          if (cyc - prev != WAIT_CYCLES + 3) begin
            failures++;
            $display("FAIL b2b_spacing: got %0d edges expected %0d", cyc - prev, WAIT_CYCLES + 3);
          end
        end
        prev = cyc;
        n_acc++;
        just_acc = 1'b1;
      end
    end
    checks++;
    if (q.size() != 0 || n_acc < 20) begin
      failures++;
      $display("FAIL b2b_drain: got pending=%0d accepts=%0d expected 0 and >=20", q.size(), n_acc);
    end
    rsp_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_init_memory();
    test_store_load();
    test_range_error();
    test_hold();
    test_reset_abort();
    test_random();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
